// File: rtl/cpu_pkg.sv
// Shared types and reset/vector constants for the cpu_seq sequencer.
// Optional macro CPU_SEQ_IRQ_EN adds the IRQ state and IRQ_VEC.
package cpu_pkg;

    localparam int unsigned CONST_W = 16;

    localparam logic [CONST_W-1:0] RESET_PC = 16'h0400;
    localparam logic [CONST_W-1:0] RESET_SP = 16'hFFFE;
`ifdef CPU_SEQ_IRQ_EN
    localparam logic [CONST_W-1:0] IRQ_VEC  = 16'h0010;
`endif

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_ALU    = 3'd1,
        OP_BRANCH = 3'd2,
        OP_JUMP   = 3'd3,
        OP_PUSH   = 3'd4,
        OP_POP    = 3'd5,
        OP_LOAD   = 3'd6,
        OP_STORE  = 3'd7
    } op_class_e;

`ifdef CPU_SEQ_IRQ_EN
    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_EX    = 3'd1,
        ST_MEM   = 3'd2,
        ST_WB    = 3'd3,
        ST_IRQ   = 3'd4
    } state_e;
`else
    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_EX    = 3'd1,
        ST_MEM   = 3'd2,
        ST_WB    = 3'd3
    } state_e;
`endif

    // Classes that need a data-memory phase.
    function automatic logic is_mem_op(input op_class_e op);
        return (op == OP_PUSH) || (op == OP_POP) || (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/cpu_seq_fsm.sv
// Sequencer state register, next-state logic and registered phase strobes.
// IRQ state present only when CPU_SEQ_IRQ_EN is defined.
module cpu_seq_fsm
    import cpu_pkg::*;
(
    input  logic      clk,
    input  logic      resetn,
    input  logic      i_if_ack,
    input  logic      i_dm_ack,
    input  op_class_e i_op,
`ifdef CPU_SEQ_IRQ_EN
    input  logic      i_irq_take,
`endif
    output state_e    o_state,
    output state_e    o_next_c,
    output logic      o_if_req,
    output logic      o_dm_req,
    output logic      o_ex_en,
    output logic      o_wb_en
);

    state_e r_state;
    state_e w_next;
    logic   r_if_req;
    logic   r_dm_req;
    logic   r_ex_en;
    logic   r_wb_en;
    logic   w_if_req_d;
    logic   w_dm_req_d;
    logic   w_ex_en_d;
    logic   w_wb_en_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= ST_FETCH;
            r_if_req <= 1'b0;
            r_dm_req <= 1'b0;
            r_ex_en  <= 1'b0;
            r_wb_en  <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_if_req <= w_if_req_d;
            r_dm_req <= w_dm_req_d;
            r_ex_en  <= w_ex_en_d;
            r_wb_en  <= w_wb_en_d;
        end
    end

    // Strobes are registered from the next state so they line up with the state they describe.
    always_comb begin
        w_next     = r_state;
        w_if_req_d = 1'b0;
        w_dm_req_d = 1'b0;
        w_ex_en_d  = 1'b0;
        w_wb_en_d  = 1'b0;
        case (r_state)
            ST_FETCH: if (r_if_req && i_if_ack) w_next = ST_EX;
            ST_EX:    w_next = is_mem_op(i_op) ? ST_MEM : ST_WB;
            ST_MEM:   if (i_dm_ack) w_next = ST_WB;
`ifdef CPU_SEQ_IRQ_EN
            ST_WB:    w_next = i_irq_take ? ST_IRQ : ST_FETCH;
            ST_IRQ:   if (i_dm_ack) w_next = ST_FETCH;
`else
            ST_WB:    w_next = ST_FETCH;
`endif
            default:  w_next = ST_FETCH;
        endcase
        w_if_req_d = (w_next == ST_FETCH);
        w_dm_req_d = (w_next == ST_MEM);
`ifdef CPU_SEQ_IRQ_EN
        w_dm_req_d = w_dm_req_d || (w_next == ST_IRQ);
`endif
        w_ex_en_d  = (w_next == ST_EX);
        w_wb_en_d  = (w_next == ST_WB);
    end

    assign o_state  = r_state;
    assign o_next_c = w_next;
    assign o_if_req = r_if_req;
    assign o_dm_req = r_dm_req;
    assign o_ex_en  = r_ex_en;
    assign o_wb_en  = r_wb_en;

endmodule

// File: rtl/cpu_seq.sv
// Multi-cycle instruction sequencer: pc/sp/sreg datapath around cpu_seq_fsm.
// Define CPU_SEQ_IRQ_EN to enable interrupt entry after WB.
module cpu_seq #(
    parameter int unsigned     AW       = 16,
    parameter int unsigned     SRW      = 16,
    parameter logic [AW-1:0]   RESET_PC = AW'(cpu_pkg::RESET_PC),
    parameter logic [AW-1:0]   RESET_SP = AW'(cpu_pkg::RESET_SP)
`ifdef CPU_SEQ_IRQ_EN
   ,parameter logic [AW-1:0]   IRQ_VEC  = AW'(cpu_pkg::IRQ_VEC)
`endif
) (
    input  logic           clk,
    input  logic           resetn,
    output logic           if_req,
    input  logic           if_ack,
    input  logic [2:0]     op_class,
    input  logic           br_taken,
    input  logic [AW-1:0]  target,
    output logic           dm_req,
    output logic           dm_we,
    output logic [AW-1:0]  dm_addr,
    input  logic           dm_ack,
    input  logic [AW-1:0]  ea,
    input  logic           sreg_we,
    input  logic [SRW-1:0] sreg_wdata,
    input  logic           irq,
    output logic [AW-1:0]  pc,
    output logic [AW-1:0]  sp,
    output logic [SRW-1:0] sreg,
    output logic [2:0]     phase,
    output logic           ex_en,
    output logic           wb_en
);

    import cpu_pkg::*;

    state_e         w_state;
    state_e         w_next;
    logic           w_if_req;
    logic           w_fetch_fire;
    logic           w_acc_next;
    logic [AW-1:0]  w_sp_dec;
    logic [AW-1:0]  w_sp_inc;
    op_class_e      r_op;
    logic           r_taken;
    logic [AW-1:0]  r_target;
    logic [AW-1:0]  r_pc;
    logic [AW-1:0]  r_sp;
    logic [SRW-1:0] r_sreg;
    logic           r_dm_we;
    logic [AW-1:0]  r_dm_addr;

`ifdef CPU_SEQ_IRQ_EN
    logic           w_irq_take;

    // IE is judged on the value sreg will hold after this WB's write.
    assign w_irq_take = irq && (sreg_we ? sreg_wdata[0] : r_sreg[0]);
`else
    logic           w_unused_irq;
    assign w_unused_irq = irq;
`endif

    cpu_seq_fsm u_fsm (
        .clk        (clk),
        .resetn     (resetn),
        .i_if_ack   (if_ack),
        .i_dm_ack   (dm_ack),
        .i_op       (r_op),
`ifdef CPU_SEQ_IRQ_EN
        .i_irq_take (w_irq_take),
`endif
        .o_state    (w_state),
        .o_next_c   (w_next),
        .o_if_req   (w_if_req),
        .o_dm_req   (dm_req),
        .o_ex_en    (ex_en),
        .o_wb_en    (wb_en)
    );

    assign w_fetch_fire = (w_state == ST_FETCH) && w_if_req && if_ack;
    assign w_sp_dec     = r_sp - AW'(2);
    assign w_sp_inc     = r_sp + AW'(2);
`ifdef CPU_SEQ_IRQ_EN
    assign w_acc_next   = (w_next == ST_MEM) || (w_next == ST_IRQ);
`else
    assign w_acc_next   = (w_next == ST_MEM);
`endif

    // Instruction fields captured on the accepted fetch.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_op     <= OP_NOP;
            r_taken  <= 1'b0;
            r_target <= '0;
        end else if (w_fetch_fire) begin
            r_op     <= op_class_e'(op_class);
            r_taken  <= br_taken;
            r_target <= target;
        end
    end

    // Data request address/direction, frozen for the whole access.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_dm_addr <= '0;
            r_dm_we   <= 1'b0;
        end else if ((w_state == ST_EX) && (w_next == ST_MEM)) begin
            case (r_op)
                OP_PUSH:  begin r_dm_addr <= w_sp_dec; r_dm_we <= 1'b1; end
                OP_POP:   begin r_dm_addr <= r_sp;     r_dm_we <= 1'b0; end
                OP_LOAD:  begin r_dm_addr <= ea;       r_dm_we <= 1'b0; end
                OP_STORE: begin r_dm_addr <= ea;       r_dm_we <= 1'b1; end
                default:  begin r_dm_addr <= '0;       r_dm_we <= 1'b0; end
            endcase
`ifdef CPU_SEQ_IRQ_EN
        end else if ((w_state == ST_WB) && (w_next == ST_IRQ)) begin
            r_dm_addr <= w_sp_dec;
            r_dm_we   <= 1'b1;
`endif
        end else if (!w_acc_next) begin
            r_dm_addr <= '0;
            r_dm_we   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pc <= RESET_PC;
        end else if (w_state == ST_WB) begin
            r_pc <= ((r_op == OP_JUMP) || ((r_op == OP_BRANCH) && r_taken)) ? r_target
                                                                             : r_pc + AW'(1);
`ifdef CPU_SEQ_IRQ_EN
        end else if ((w_state == ST_IRQ) && dm_ack) begin
            r_pc <= IRQ_VEC;
`endif
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sp <= RESET_SP;
        end else if ((w_state == ST_MEM) && dm_ack) begin
            if (r_op == OP_PUSH) r_sp <= w_sp_dec;
            else if (r_op == OP_POP) r_sp <= w_sp_inc;
`ifdef CPU_SEQ_IRQ_EN
        end else if ((w_state == ST_IRQ) && dm_ack) begin
            r_sp <= w_sp_dec;
`endif
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sreg <= SRW'(1);
        end else if ((w_state == ST_WB) && sreg_we) begin
            r_sreg <= sreg_wdata;
`ifdef CPU_SEQ_IRQ_EN
        end else if ((w_state == ST_IRQ) && dm_ack) begin
            r_sreg[0] <= 1'b0;
`endif
        end
    end

    assign if_req  = w_if_req;
    assign dm_we   = r_dm_we;
    assign dm_addr = r_dm_addr;
    assign pc      = r_pc;
    assign sp      = r_sp;
    assign sreg    = r_sreg;
    assign phase   = w_state;

endmodule
